// File: rtl/game_reset_sequencer.sv
// Staged reset generator for the game-clock domain: waits for a stable PLL lock,
// releases stage resets one at a time, and re-asserts them all on lock loss.
module game_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 16,
    parameter int NUM_STAGES         = 3,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_lock,
    input  logic                  soft_rst_req,
    output logic [NUM_STAGES-1:0] rst_stage,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic [1:0]            state_o
);

    localparam int MAX_CNT = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, sync1_d;
    logic                    lock_s_q, lock_s_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_STAGES-1:0]   rst_stage_q, rst_stage_d;
    logic                    ready_q, ready_d;
    logic [LOSS_CNT_W-1:0]   loss_cnt_q, loss_cnt_d;

    always_comb begin
        sync1_d     = pll_lock;
        lock_s_d    = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rst_stage_d = rst_stage_q;
        ready_d     = ready_q;
        loss_cnt_d  = loss_cnt_q;

        case (state_q)
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                end
            end
            ST_STABLE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!lock_s_q) begin
                    state_d     = ST_WAIT_LOCK;
                    cnt_d       = '0;
                    rst_stage_d = '1;
                    ready_d     = 1'b0;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            rst_stage_d[i] = 1'b0;
                        end
                    end
                    // The edge that frees the last stage also declares ready.
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d     = ST_WAIT_LOCK;
                    cnt_d       = '0;
                    rst_stage_d = '1;
                    ready_d     = 1'b0;
                    if (loss_cnt_q != '1) begin
                        loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
                    end
                end else if (soft_rst_req) begin
                    state_d     = ST_RELEASE;
                    cnt_d       = '0;
                    idx_d       = '0;
                    rst_stage_d = '1;
                    ready_d     = 1'b0;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_WAIT_LOCK;
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            rst_stage_q <= '1;
            ready_q     <= 1'b0;
            loss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            lock_s_q    <= lock_s_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rst_stage_q <= rst_stage_d;
            ready_q     <= ready_d;
            loss_cnt_q  <= loss_cnt_d;
        end
    end

    assign rst_stage     = rst_stage_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = loss_cnt_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_game_reset_sequencer.sv
// Directed bench for game_reset_sequencer with LSC=8, GAP=4, N=3, LOSS_CNT_W=2.
module tb_game_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       soft_rst_req;
    logic [2:0] rst_stage;
    logic       ready;
    logic [1:0] lock_loss_cnt;
    logic [1:0] state_o;

    int n_checks;
    int n_pass;
    logic [1:0] exp_cnt;

    game_reset_sequencer #(
        .LOCK_STABLE_CYCLES(8),
        .STAGE_GAP(4),
        .NUM_STAGES(3),
        .LOSS_CNT_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pll_lock(pll_lock),
        .soft_rst_req(soft_rst_req),
        .rst_stage(rst_stage),
        .ready(ready),
        .lock_loss_cnt(lock_loss_cnt),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        pll_lock     = 1'b0;
        soft_rst_req = 1'b0;
        step(3);
        rst = 1'b0;
    endtask

    // Raises pll_lock; the next edge is e0. Checks stage release timing through e22.
    task automatic run_release(input string tag);
        pll_lock = 1'b1;
        step(14);
        n_checks++;
        if (rst_stage !== 3'b111 || state_o !== 2'd2)
            $display("FAIL %s_e13: rst_stage=%b state=%0d, need 111/2", tag, rst_stage, state_o);
        else n_pass++;
        step(1);
        n_checks++;
        if (rst_stage !== 3'b110)
            $display("FAIL %s_e14: rst_stage=%b, need 110", tag, rst_stage);
        else n_pass++;
        step(4);
        n_checks++;
        if (rst_stage !== 3'b100)
            $display("FAIL %s_e18: rst_stage=%b, need 100", tag, rst_stage);
        else n_pass++;
        step(3);
        n_checks++;
        if (rst_stage !== 3'b100 || ready !== 1'b0)
            $display("FAIL %s_e21: rst_stage=%b ready=%b, need 100/0", tag, rst_stage, ready);
        else n_pass++;
        step(1);
        n_checks++;
        if (rst_stage !== 3'b000 || ready !== 1'b1 || state_o !== 2'd3)
            $display("FAIL %s_e22: rst_stage=%b ready=%b state=%0d, need 000/1/3",
                     tag, rst_stage, ready, state_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (rst_stage !== 3'b111 || ready !== 1'b0 || lock_loss_cnt !== 2'd0 || state_o !== 2'd0)
            $display("FAIL reset: rst_stage=%b ready=%b cnt=%0d state=%0d, need 111/0/0/0",
                     rst_stage, ready, lock_loss_cnt, state_o);
        else n_pass++;
    endtask

    task automatic test_release();
        run_release("release");
    endtask

    task automatic test_stable_glitch();
        do_reset();
        pll_lock = 1'b1;
        step(7);                       // after e6: STABLE for 5 edges
        n_checks++;
        if (state_o !== 2'd1)
            $display("FAIL glitch_stable: state=%0d, need 1", state_o);
        else n_pass++;
        pll_lock = 1'b0;
        step(2);
        n_checks++;
        if (state_o !== 2'd1)
            $display("FAIL glitch_hold: state=%0d, need 1", state_o);
        else n_pass++;
        step(1);
        n_checks++;
        if (state_o !== 2'd0 || lock_loss_cnt !== 2'd0)
            $display("FAIL glitch_wait: state=%0d cnt=%0d, need 0/0", state_o, lock_loss_cnt);
        else n_pass++;
        run_release("glitch_relock");
        n_checks++;
        if (lock_loss_cnt !== 2'd0)
            $display("FAIL glitch_cnt: cnt=%0d, need 0", lock_loss_cnt);
        else n_pass++;
    endtask

    task automatic test_run_loss();
        pll_lock = 1'b0;
        step(2);
        n_checks++;
        if (rst_stage !== 3'b000 || ready !== 1'b1)
            $display("FAIL loss_early: rst_stage=%b ready=%b, need 000/1", rst_stage, ready);
        else n_pass++;
        step(1);
        exp_cnt = 2'd1;
        n_checks++;
        if (rst_stage !== 3'b111 || ready !== 1'b0 || state_o !== 2'd0 || lock_loss_cnt !== exp_cnt)
            $display("FAIL loss_assert: rst_stage=%b ready=%b state=%0d cnt=%0d, need 111/0/0/%0d",
                     rst_stage, ready, state_o, lock_loss_cnt, exp_cnt);
        else n_pass++;
        run_release("loss_relock");
    endtask

    task automatic test_soft_reset();
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
        n_checks++;
        if (rst_stage !== 3'b111 || state_o !== 2'd2 || ready !== 1'b0)
            $display("FAIL soft_assert: rst_stage=%b state=%0d ready=%b, need 111/2/0",
                     rst_stage, state_o, ready);
        else n_pass++;
        step(4);
        n_checks++;
        if (rst_stage !== 3'b110)
            $display("FAIL soft_stage0: rst_stage=%b, need 110", rst_stage);
        else n_pass++;
        step(7);
        n_checks++;
        if (ready !== 1'b0)
            $display("FAIL soft_early: ready=%b, need 0", ready);
        else n_pass++;
        step(1);
        n_checks++;
        if (ready !== 1'b1 || rst_stage !== 3'b000 || state_o !== 2'd3)
            $display("FAIL soft_ready: ready=%b rst_stage=%b state=%0d, need 1/000/3",
                     ready, rst_stage, state_o);
        else n_pass++;

        // Soft request while STABLE must be ignored.
        do_reset();
        exp_cnt = 2'd0;
        pll_lock = 1'b1;
        step(5);
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
        n_checks++;
        if (state_o !== 2'd1 || rst_stage !== 3'b111)
            $display("FAIL soft_stable: state=%0d rst_stage=%b, need 1/111", state_o, rst_stage);
        else n_pass++;
        step(9);
        n_checks++;
        if (rst_stage !== 3'b110)
            $display("FAIL soft_stable_e14: rst_stage=%b, need 110", rst_stage);
        else n_pass++;
        step(8);
        n_checks++;
        if (ready !== 1'b1 || state_o !== 2'd3)
            $display("FAIL soft_stable_e22: ready=%b state=%0d, need 1/3", ready, state_o);
        else n_pass++;

        // Lock loss wins over a simultaneous soft request.
        pll_lock = 1'b0;
        step(2);
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
        exp_cnt = 2'd1;
        n_checks++;
        if (state_o !== 2'd0 || rst_stage !== 3'b111 || lock_loss_cnt !== exp_cnt)
            $display("FAIL soft_vs_loss: state=%0d rst_stage=%b cnt=%0d, need 0/111/%0d",
                     state_o, rst_stage, lock_loss_cnt, exp_cnt);
        else n_pass++;
        run_release("soft_relock");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 4; i++) begin
            pll_lock = 1'b0;
            step(3);
            if (exp_cnt != 2'b11) exp_cnt = exp_cnt + 2'd1;
            n_checks++;
            if (lock_loss_cnt !== exp_cnt || state_o !== 2'd0)
                $display("FAIL saturate_%0d: cnt=%0d state=%0d, need %0d/0",
                         i, lock_loss_cnt, state_o, exp_cnt);
            else n_pass++;
            pll_lock = 1'b1;
            step(23);
        end
        n_checks++;
        if (lock_loss_cnt !== 2'b11 || ready !== 1'b1)
            $display("FAIL saturate_final: cnt=%0d ready=%b, need 3/1", lock_loss_cnt, ready);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        pll_lock = 1'b1;
        step(16);
        n_checks++;
        if (rst_stage !== 3'b110 || state_o !== 2'd2)
            $display("FAIL async_pre: rst_stage=%b state=%0d, need 110/2", rst_stage, state_o);
        else n_pass++;
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (rst_stage !== 3'b111 || ready !== 1'b0 || lock_loss_cnt !== 2'd0 || state_o !== 2'd0)
            $display("FAIL async_rst: rst_stage=%b ready=%b cnt=%0d state=%0d, need 111/0/0/0",
                     rst_stage, ready, lock_loss_cnt, state_o);
        else n_pass++;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        exp_cnt      = 2'd0;
        rst          = 1'b1;
        pll_lock     = 1'b0;
        soft_rst_req = 1'b0;
        test_reset();
        test_release();
        test_stable_glitch();
        test_run_loss();
        test_soft_reset();
        test_saturate();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
